// File: rtl/dm_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dm_resp
//  Description : Single-port data-memory responder. A CPU request is latched
//                in IDLE, held for a programmable number of wait cycles and
//                answered with a one-cycle ready pulse carrying rdata/err.
//                64-word (AW=6) register array with a combinational debug tap.
//                Optional macro DM_BYTE_WRITE_EN enables byte-lane writes;
//                without it every valid write updates the whole word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_resp #(
  parameter int WAIT = 2,
  parameter int AW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic          ready,
  output logic [31:0]   rdata,
  output logic          err,
  input  logic [AW-1:0] mem_sel,
  output logic [31:0]   mem_data
);

  localparam int         C_DEPTH = 1 << AW;
  localparam logic [3:0] C_WAIT  = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [C_DEPTH];
  logic [31:0] mem_d [C_DEPTH];

  logic          w_acc_we;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic [3:0]    w_acc_be;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic [31:0]   w_mask;
  logic [31:0]   w_merged;
  logic          w_enter;

  // With WAIT=0 the access completes on the accepting edge, so the live
  // inputs are used in IDLE; otherwise the latched copy is used.
  assign w_acc_we    = (state_q == IDLE) ? we    : we_q;
  assign w_acc_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign w_acc_wdata = (state_q == IDLE) ? wdata : wdata_q;
  assign w_acc_be    = (state_q == IDLE) ? be    : be_q;

  assign w_idx = w_acc_addr[AW+1:2];
  assign w_err = (w_acc_addr[1:0] != 2'b00) || (|w_acc_addr[31:AW+2]);

`ifdef DM_BYTE_WRITE_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_mask
    assign w_mask[8*gi +: 8] = {8{w_acc_be[gi]}};
  end
`else
  logic w_be_unused;
  assign w_mask      = 32'hFFFF_FFFF;
  assign w_be_unused = ^w_acc_be;
`endif

  assign w_merged = (mem_q[w_idx] & ~w_mask) | (w_acc_wdata & w_mask);

  // Next-state, access latch, response and storage update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    w_enter = 1'b0;
    mem_d   = mem_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          cnt_d   = C_WAIT;
          if (C_WAIT == 4'd0) begin
            state_d = RESP;
            w_enter = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          w_enter = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The edge entering RESP commits a write or captures read data
    if (w_enter) begin
      ready_d = 1'b1;
      err_d   = w_err;
      if (!w_err) begin
        if (w_acc_we) begin
          mem_d[w_idx] = w_merged;
        end else begin
          rdata_d = mem_q[w_idx];
        end
      end
    end
  end

  // State, latched access, response and storage registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      for (int i = 0; i < C_DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign rdata    = rdata_q;
  assign mem_data = mem_q[mem_sel];

endmodule
`default_nettype wire

// File: tb/tb_dm_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_resp
//  Description : Self-checking bench for dm_resp. Two instances (WAIT=2 and
//                WAIT=0) share clock and reset; a transaction-level model
//                predicts every response and the debug word each cycle.
//                Honours DM_BYTE_WRITE_EN when predicting partial writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_resp;

  localparam int AW = 6;

`ifdef DM_BYTE_WRITE_EN
  localparam logic [31:0] EXP_PART = 32'hDE22_BE44;
`else
  localparam logic [31:0] EXP_PART = 32'h1122_3344;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req      [2];
  logic          we       [2];
  logic [31:0]   addr     [2];
  logic [31:0]   wdata    [2];
  logic [3:0]    be       [2];
  logic          ready    [2];
  logic [31:0]   rdata    [2];
  logic          err      [2];
  logic [AW-1:0] mem_sel  [2];
  logic [31:0]   mem_data [2];

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  always #5 clk = ~clk;

  dm_resp #(.WAIT(2), .AW(AW)) u_w2 (
    .clk(clk), .rst(rst), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .ready(ready[0]), .rdata(rdata[0]),
    .err(err[0]), .mem_sel(mem_sel[0]), .mem_data(mem_data[0])
  );

  dm_resp #(.WAIT(0), .AW(AW)) u_w0 (
    .clk(clk), .rst(rst), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .ready(ready[1]), .rdata(rdata[1]),
    .err(err[1]), .mem_sel(mem_sel[1]), .mem_data(mem_data[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  string       nm [2] = '{"w2", "w0"};
  int          mwait [2] = '{2, 0};
  int          edge_n = 0;
  logic [31:0] mmem [2][64];
  bit          pend [2];
  int          resp_e [2];
  int          free_e [2];
  logic        p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  logic [3:0]  p_be [2];
  logic        x_ready [2];
  logic        x_err [2];
  logic [31:0] x_rdata [2];
  bit          x_rd_valid [2];

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      for (int i = 0; i < 2; i++) begin
        x_ready[i]    = 1'b0;
        x_err[i]      = 1'b0;
        x_rdata[i]    = 32'h0;
        x_rd_valid[i] = 1'b1;
        if (!rst) begin
          pend[i]   = 1'b0;
          free_e[i] = 0;
          for (int j = 0; j < 64; j++) mmem[i][j] = 32'h0;
        end else begin
          if (!pend[i] && edge_n >= free_e[i] && req[i]) begin
            pend[i]    = 1'b1;
            p_we[i]    = we[i];
            p_addr[i]  = addr[i];
            p_wdata[i] = wdata[i];
            p_be[i]    = be[i];
            resp_e[i]  = edge_n + ((mwait[i] == 0) ? 0 : mwait[i] + 1);
          end
          if (pend[i] && edge_n == resp_e[i]) begin
            logic        e;
            logic [31:0] m;
            logic [5:0]  idx;
            idx = p_addr[i][7:2];
            e   = (p_addr[i][1:0] != 2'b00) || (p_addr[i][31:8] != 24'h0);
`ifdef DM_BYTE_WRITE_EN
            m = {{8{p_be[i][3]}}, {8{p_be[i][2]}}, {8{p_be[i][1]}}, {8{p_be[i][0]}}};
`else
            m = 32'hFFFF_FFFF;
`endif
            x_ready[i] = 1'b1;
            x_err[i]   = e;
            if (!e && !p_we[i]) x_rdata[i] = mmem[i][idx];
            if (!e && p_we[i]) begin
              x_rd_valid[i] = 1'b0;
              mmem[i][idx]  = (mmem[i][idx] & ~m) | (p_wdata[i] & m);
            end
            pend[i]   = 1'b0;
            free_e[i] = edge_n + 2;
          end
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        for (int i = 0; i < 2; i++) begin
          chk({nm[i], ".ready"}, {31'b0, ready[i]}, {31'b0, x_ready[i]});
          chk({nm[i], ".err"}, {31'b0, err[i]}, {31'b0, x_err[i]});
          if (x_rd_valid[i]) chk({nm[i], ".rdata"}, rdata[i], x_rdata[i]);
          chk({nm[i], ".mem_data"}, mem_data[i], mmem[i][mem_sel[i]]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    step();
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    step();
    req[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready[i] && n < 20);
    if (!ready[i]) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: no ready within %0d cycles", nm[i], n);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int t1;
    int t2;
    int pulses;
    logic [31:0] got;

    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
      be[i] = 4'h0; mem_sel[i] = '0;
    end
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    chk("reset.ready", {31'b0, ready[0]}, 32'h0);
    chk("reset.rdata", rdata[0], 32'h0);
    chk("reset.mem0", mem_data[0], 32'h0);

    // full-word write, WAIT=2: ready four negedges after acceptance
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    wait_ready(0, n);
    chk("wr.latency", n, 32'd4);
    chk("wr.err", {31'b0, err[0]}, 32'h0);
    step();
    mem_sel[0] = 6'd4;
    #1;
    chk("wr.word4", mem_data[0], 32'hDEAD_BEEF);

    // read with req held through BUSY and RESP: one pulse only
    step();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; be[0] = 4'hF;
    pulses = 0;
    got = 32'h0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 4) req[0] = 1'b0;
      if (ready[0]) begin
        pulses++;
        got = rdata[0];
      end
    end
    chk("held.pulses", pulses, 32'd1);
    chk("held.rdata", got, 32'hDEAD_BEEF);

    // partial-enable write over DEADBEEF
    issue(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101);
    wait_ready(0, n);
    step();
    chk("part.word4", mem_data[0], EXP_PART);

    // misaligned and out-of-range writes are rejected
    issue(0, 1'b1, 32'h12, 32'hCAFE_F00D, 4'hF);
    wait_ready(0, n);
    chk("mis.err", {31'b0, err[0]}, 32'h1);
    chk("mis.rdata", rdata[0], 32'h0);
    step();
    chk("mis.word4", mem_data[0], EXP_PART);
    issue(0, 1'b1, 32'h100, 32'hCAFE_F00D, 4'hF);
    wait_ready(0, n);
    chk("oor.err", {31'b0, err[0]}, 32'h1);
    chk("oor.rdata", rdata[0], 32'h0);
    step();
    chk("oor.word4", mem_data[0], EXP_PART);

    // WAIT=0: one-edge latency, back-to-back reads every second cycle
    issue(1, 1'b1, 32'h8, 32'h0000_00A5, 4'hF);
    wait_ready(1, n);
    chk("z.wr.latency", n, 32'd1);
    issue(1, 1'b0, 32'h8, 32'h0, 4'hF);
    wait_ready(1, n);
    t1 = edge_n;
    chk("z.rd1.latency", n, 32'd1);
    chk("z.rd1.rdata", rdata[1], 32'h0000_00A5);
    issue(1, 1'b0, 32'h10, 32'h0, 4'hF);
    wait_ready(1, n);
    t2 = edge_n;
    chk("z.rd2.latency", n, 32'd1);
    chk("z.rd2.gap", t2 - t1, 32'd2);
    chk("z.rd2.rdata", rdata[1], 32'h0);

    // reset during BUSY discards the write; first post-reset edge accepts
    step();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'h5; be[0] = 4'hF;
    step();
    req[0] = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
    step();
    req[0] = 1'b0;
    wait_ready(0, n);
    chk("rst.accept.latency", n, 32'd4);
    chk("rst.rd.rdata", rdata[0], 32'h0);
    step();
    mem_sel[0] = 6'd0;
    #1;
    chk("rst.word0", mem_data[0], 32'h0);

    repeat (3) step();
    done = 1'b1;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
